// File: rtl/atari7800_pkg.sv
// Shared types and constants for the Atari 7800 system-bus logic.
package atari7800_pkg;

    // Width of the system address bus.
    localparam int BUS_AW = 16;

    // Byte written to every RAM location during a clear sweep.
    localparam logic [7:0] CLR_DATA_DEFAULT = 8'hFF;

    // Current bus owner; the encoding is visible on the owner output.
    typedef enum logic [1:0] {
        OWN_CPU       = 2'd0,
        OWN_HALT_PEND = 2'd1,
        OWN_DMA       = 2'd2,
        OWN_CLEAR     = 2'd3
    } bus_owner_t;

endpackage

// File: rtl/ram_clear_seq.sv
// RAM clear sweep: detects a rising edge of loading and steps an address
// counter through every location once, one location per clk_sys.
module ram_clear_seq
    import atari7800_pkg::*;
#(
    parameter int CLR_AW = 11
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              loading,
    output logic              clr_start,
    output logic              clr_busy,
    output logic [BUS_AW-1:0] clr_ab
);

    localparam logic [CLR_AW-1:0] CNT_ONE = {{(CLR_AW-1){1'b0}}, 1'b1};

    logic              loading_q;
    logic              busy_q, busy_d;
    logic [CLR_AW-1:0] cnt_q, cnt_d;

    // An edge arriving mid-sweep is ignored so the counter never restarts.
    assign clr_start = loading & ~loading_q & ~busy_q;
    assign clr_busy  = busy_q;

    // Next sweep state: start at 0, stop after the all-ones address.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (clr_start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q) begin
            if (&cnt_q) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Sweep registers; on reset the edge detector takes the current loading
    // level so a level held through reset does not look like a new edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            loading_q <= loading;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            loading_q <= loading;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    // Zero-extend the sweep counter onto the full bus width.
    always_comb begin
        clr_ab             = '0;
        clr_ab[CLR_AW-1:0] = cnt_q;
    end

endmodule

// File: rtl/bus_arbiter.sv
// System bus arbiter: shares the bus between the CPU, MARIA DMA and the
// RAM clear sweep triggered by cartridge loading.
module bus_arbiter
    import atari7800_pkg::*;
#(
    parameter int         CLR_AW   = 11,
    parameter logic [7:0] CLR_DATA = CLR_DATA_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              pclk0,
    input  logic              loading,
    input  logic              halt_unlock,
    input  logic              dma_req,
    input  logic [BUS_AW-1:0] dma_addr,
    input  logic [BUS_AW-1:0] cpu_addr,
    input  logic              cpu_rwn,
    input  logic [7:0]        cpu_wdata,
    output logic [BUS_AW-1:0] AB,
    output logic              RW,
    output logic [7:0]        WDATA,
    output logic              ram_wr_all,
    output logic              dma_gnt,
    output logic              cpu_rdy,
    output logic              clr_busy,
    output logic [1:0]        owner
);

    bus_owner_t        state_q;
    logic              dma_gnt_q;
    logic              cpu_rdy_q;
    logic              clr_start;
    logic [BUS_AW-1:0] clr_ab;

    ram_clear_seq #(
        .CLR_AW (CLR_AW)
    ) u_clear (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .loading   (loading),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_ab    (clr_ab)
    );

    // Ownership FSM; a clear request wins over any bus-cycle transition.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= OWN_CPU;
            dma_gnt_q <= 1'b0;
            cpu_rdy_q <= 1'b1;
        end else if (clr_start) begin
            state_q   <= OWN_CLEAR;
            dma_gnt_q <= 1'b0;
            cpu_rdy_q <= 1'b0;
        end else begin
            case (state_q)
                OWN_CPU: begin
                    if (pclk0 && dma_req && halt_unlock) begin
                        state_q   <= OWN_HALT_PEND;
                        cpu_rdy_q <= 1'b0;
                    end
                end
                OWN_HALT_PEND: begin
                    // One extra bus cycle lets an in-flight CPU write finish.
                    if (pclk0) begin
                        state_q   <= OWN_DMA;
                        dma_gnt_q <= 1'b1;
                    end
                end
                OWN_DMA: begin
                    if (pclk0 && !dma_req) begin
                        state_q   <= OWN_CPU;
                        dma_gnt_q <= 1'b0;
                        cpu_rdy_q <= 1'b1;
                    end
                end
                OWN_CLEAR: begin
                    // Hand the bus back only on a bus-cycle boundary.
                    if (!clr_busy && pclk0) begin
                        if (dma_req && halt_unlock) begin
                            state_q <= OWN_HALT_PEND;
                        end else begin
                            state_q   <= OWN_CPU;
                            cpu_rdy_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= OWN_CPU;
                    dma_gnt_q <= 1'b0;
                    cpu_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    assign dma_gnt    = dma_gnt_q;
    assign cpu_rdy    = cpu_rdy_q;
    assign owner      = state_q;
    assign ram_wr_all = clr_busy;

    // Bus drive mux; after a sweep the CPU drive is presented until handover.
    always_comb begin
        AB    = cpu_addr;
        RW    = cpu_rwn;
        WDATA = cpu_wdata;
        if (clr_busy) begin
            AB    = clr_ab;
            RW    = 1'b0;
            WDATA = CLR_DATA;
        end else if (state_q == OWN_DMA) begin
            AB = dma_addr;
            RW = 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, hand-written sweep and
// reset sequences, and randomized traffic against a behavioural model.
module tb_bus_arbiter;

    localparam int AW = 11;
    localparam int N  = 1 << AW;
    localparam int O_CPU  = 0;
    localparam int O_HALT = 1;
    localparam int O_DMA  = 2;
    localparam int O_CLR  = 3;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        pclk0 = 1'b0;
    logic        loading = 1'b0;
    logic        halt_unlock = 1'b0;
    logic        dma_req = 1'b0;
    logic [15:0] dma_addr = 16'h0000;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_rwn = 1'b1;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [15:0] AB;
    logic        RW;
    logic [7:0]  WDATA;
    logic        ram_wr_all, dma_gnt, cpu_rdy, clr_busy;
    logic [1:0]  owner;

    bus_arbiter #(.CLR_AW(AW), .CLR_DATA(8'hFF)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .pclk0       (pclk0),
        .loading     (loading),
        .halt_unlock (halt_unlock),
        .dma_req     (dma_req),
        .dma_addr    (dma_addr),
        .cpu_addr    (cpu_addr),
        .cpu_rwn     (cpu_rwn),
        .cpu_wdata   (cpu_wdata),
        .AB          (AB),
        .RW          (RW),
        .WDATA       (WDATA),
        .ram_wr_all  (ram_wr_all),
        .dma_gnt     (dma_gnt),
        .cpu_rdy     (cpu_rdy),
        .clr_busy    (clr_busy),
        .owner       (owner)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus, and how many sweep writes remain.
    int m_own = O_CPU;
    int m_left = 0;
    bit m_prev_load = 1'b0;

    task automatic model_step();
        bit busy_old, rise;
        if (reset) begin
            m_own = O_CPU;
            m_left = 0;
            m_prev_load = loading;
        end else begin
            busy_old = (m_left > 0);
            rise = loading && !m_prev_load;
            m_prev_load = loading;
            if (busy_old) m_left--;
            if (rise && !busy_old) begin
                m_own = O_CLR;
                m_left = N;
            end else begin
                case (m_own)
                    O_CPU:  if (pclk0 && dma_req && halt_unlock) m_own = O_HALT;
                    O_HALT: if (pclk0) m_own = O_DMA;
                    O_DMA:  if (pclk0 && !dma_req) m_own = O_CPU;
                    default: if (!busy_old && pclk0) m_own = (dma_req && halt_unlock) ? O_HALT : O_CPU;
                endcase
            end
        end
    endtask

    task automatic model_check();
        int e_ab, e_rw;
        chk("owner", 32'(owner), 32'(m_own));
        chk("cpu_rdy", 32'(cpu_rdy), (m_own == O_CPU) ? 32'd1 : 32'd0);
        chk("dma_gnt", 32'(dma_gnt), (m_own == O_DMA) ? 32'd1 : 32'd0);
        chk("clr_busy", 32'(clr_busy), (m_left > 0) ? 32'd1 : 32'd0);
        chk("ram_wr_all", 32'(ram_wr_all), (m_left > 0) ? 32'd1 : 32'd0);
        if (m_left > 0) begin
            e_ab = N - m_left;
            e_rw = 0;
            chk("wdata_clear", 32'(WDATA), 32'hFF);
        end else if (m_own == O_DMA) begin
            e_ab = 32'(dma_addr);
            e_rw = 1;
        end else begin
            e_ab = 32'(cpu_addr);
            e_rw = 32'(cpu_rwn);
            chk("wdata_cpu", 32'(WDATA), 32'(cpu_wdata));
        end
        chk("AB", 32'(AB), e_ab);
        chk("RW", 32'(RW), e_rw);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        model_check();
    endtask

    int pc_phase = 0;
    task automatic step_bus();
        pclk0 = (pc_phase == 0);
        pc_phase = (pc_phase + 1) % 4;
        tick();
    endtask

    typedef struct {
        logic        rst, pclk, ld, hu, req;
        logic [15:0] daddr, caddr;
        logic        rwn;
        logic [7:0]  wd;
        int          e_own;
        logic        e_rdy, e_gnt;
        logic [15:0] e_ab;
        logic        e_rw;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int writes, last_ab, guard;
        bit seen;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1800, 16'h1234, 1'b1, 8'h00, O_CPU,  1'b1, 1'b0, 16'h1234, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1800, 16'h2000, 1'b0, 8'h5A, O_CPU,  1'b1, 1'b0, 16'h2000, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1800, 16'h2000, 1'b0, 8'h5A, O_HALT, 1'b0, 1'b0, 16'h2000, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1800, 16'h2000, 1'b0, 8'h5A, O_HALT, 1'b0, 1'b0, 16'h2000, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1800, 16'h2000, 1'b0, 8'h5A, O_DMA,  1'b0, 1'b1, 16'h1800, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1800, 16'h3000, 1'b1, 8'h11, O_CPU,  1'b1, 1'b0, 16'h3000, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1800, 16'h3000, 1'b1, 8'h11, O_CPU,  1'b1, 1'b0, 16'h3000, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1800, 16'h3000, 1'b1, 8'h11, O_HALT, 1'b0, 1'b0, 16'h3000, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1800, 16'h3000, 1'b1, 8'h11, O_DMA,  1'b0, 1'b1, 16'h1800, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1800, 16'h3000, 1'b1, 8'h11, O_CPU,  1'b1, 1'b0, 16'h3000, 1'b1};

        tick();
        tick();

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst; pclk0 = vecs[i].pclk; loading = vecs[i].ld;
            halt_unlock = vecs[i].hu; dma_req = vecs[i].req; dma_addr = vecs[i].daddr;
            cpu_addr = vecs[i].caddr; cpu_rwn = vecs[i].rwn; cpu_wdata = vecs[i].wd;
            tick();
            chk("vec_owner", 32'(owner), 32'(vecs[i].e_own));
            chk("vec_rdy", 32'(cpu_rdy), 32'(vecs[i].e_rdy));
            chk("vec_gnt", 32'(dma_gnt), 32'(vecs[i].e_gnt));
            chk("vec_ab", 32'(AB), 32'(vecs[i].e_ab));
            chk("vec_rw", 32'(RW), 32'(vecs[i].e_rw));
            chk("vec_busy", 32'(clr_busy), 32'd0);
            if (vecs[i].e_own != O_DMA) chk("vec_wdata", 32'(WDATA), 32'(vecs[i].wd));
        end

        // DMA request while halting is locked: ten bus cycles, never granted.
        halt_unlock = 1'b0; dma_req = 1'b1; pc_phase = 0;
        for (int i = 0; i < 40; i++) begin
            step_bus();
            chk("locked_gnt", 32'(dma_gnt), 32'd0);
            chk("locked_rdy", 32'(cpu_rdy), 32'd1);
        end

        // Loading rises during DMA: immediate pre-emption, full sweep, then halt.
        halt_unlock = 1'b1;
        guard = 0;
        while (owner != 2'(O_DMA) && guard < 20) begin
            step_bus();
            guard++;
        end
        chk("reach_dma", 32'(owner), 32'(O_DMA));
        loading = 1'b1;
        step_bus();
        chk("preempt_gnt", 32'(dma_gnt), 32'd0);
        chk("preempt_owner", 32'(owner), 32'(O_CLR));
        chk("sweep_first_ab", 32'(AB), 32'h0000);
        writes = 1;
        last_ab = 32'(AB);
        for (int k = 0; k < N + 10; k++) begin
            if (k == 4) loading = 1'b0;
            step_bus();
            if (!ram_wr_all) break;
            writes++;
            chk("sweep_ab_step", 32'(AB), 32'(last_ab + 1));
            last_ab = 32'(AB);
        end
        chk("sweep_count", 32'(writes), 32'(N));
        chk("sweep_last_ab", 32'(last_ab), 32'h07FF);
        chk("sweep_busy_end", 32'(clr_busy), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step_bus();
            if (pclk0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("post_sweep_pclk_seen", 32'(seen), 32'd1);
        chk("post_sweep_halt", 32'(owner), 32'(O_HALT));

        // Reset in the middle of a sweep, with loading held high through it.
        dma_req = 1'b0;
        loading = 1'b0;
        step_bus();
        loading = 1'b1;
        step_bus();
        guard = 0;
        while (AB != 16'h0400 && guard < N) begin
            step_bus();
            guard++;
        end
        chk("reach_0400", 32'(AB), 32'h0400);
        reset = 1'b1;
        step_bus();
        chk("rst_owner", 32'(owner), 32'(O_CPU));
        chk("rst_busy", 32'(clr_busy), 32'd0);
        chk("rst_rdy", 32'(cpu_rdy), 32'd1);
        chk("rst_gnt", 32'(dma_gnt), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step_bus();
            chk("rst_no_wr", 32'(ram_wr_all), 32'd0);
        end
        loading = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 9000; i++) begin
            reset = ($urandom_range(0, 1999) == 0);
            pclk0 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) dma_req = ~dma_req;
            halt_unlock = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2499) == 0) loading = 1'b1;
            else if ($urandom_range(0, 5) == 0) loading = 1'b0;
            dma_addr = 16'($urandom);
            cpu_addr = 16'($urandom);
            cpu_rwn = 1'($urandom);
            cpu_wdata = 8'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
